// File: rtl/ccff_chain_loader.sv
// Serializes host configuration words into the ccff chain head, gating the fabric
// programming clock so the chain only advances on valid bits. Optional CRC readback: CCFF_READBACK_EN.
module ccff_chain_loader #(
   parameter int unsigned CHAIN_LEN = 24,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              prog_clk_en,
   output logic              busy,
   output logic              done,
   output logic              verify_err
);

   localparam int unsigned      BL_W   = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
   localparam logic [BL_W-1:0]  WORD_C = BL_W'(WORD_W);

`ifdef CCFF_READBACK_EN
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
`endif

   state_e            state_q, state_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic [BL_W-1:0]   buf_left_q, buf_left_d;
   logic [CNT_W-1:0]  sent_q, sent_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic              head_q, head_d;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  rem_c;
   logic [BL_W-1:0]   take_c;
   logic              accept_c;

`ifdef CCFF_READBACK_EN
   logic [7:0]        crc_tx_q, crc_tx_d;
   logic [7:0]        crc_rx_q, crc_rx_d;
   logic [CNT_W-1:0]  vcnt_q, vcnt_d;
   logic              verr_q, verr_d;

   // Bit-serial CRC-8, polynomial x^8 + x^2 + x + 1.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction
`else
   logic              unused_tail_c;
   assign unused_tail_c = ccff_tail;
`endif

   assign word_ready = (state_q == S_LOAD) && (buf_left_q <= BL_W'(1)) && (acc_q < LEN_C);
   assign accept_c   = word_valid & word_ready;

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_left_d = buf_left_q;
      sent_d     = sent_q;
      acc_d      = acc_q;
      head_d     = head_q;
      en_d       = 1'b0;
      done_d     = done_q;
      rem_c      = LEN_C - acc_q;
      take_c     = (32'(rem_c) >= WORD_W) ? WORD_C : BL_W'(rem_c);
`ifdef CCFF_READBACK_EN
      crc_tx_d   = crc_tx_q;
      crc_rx_d   = crc_rx_q;
      vcnt_d     = vcnt_q;
      verr_d     = verr_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_LOAD;
               done_d     = 1'b0;
               buf_left_d = '0;
               sent_d     = '0;
               acc_d      = '0;
`ifdef CCFF_READBACK_EN
               verr_d     = 1'b0;
               crc_tx_d   = '0;
               crc_rx_d   = '0;
               vcnt_d     = '0;
`endif
            end
         end

         S_LOAD: begin
            if (sent_q == LEN_C) begin
`ifdef CCFF_READBACK_EN
               state_d = S_VERIFY;
`else
               state_d = S_DONE;
               done_d  = 1'b1;
`endif
            end else begin
               if (buf_left_q != '0) begin
                  head_d     = buf_q[0];
                  en_d       = 1'b1;
                  buf_d      = buf_q >> 1;
                  buf_left_d = buf_left_q - BL_W'(1);
                  sent_d     = sent_q + CNT_W'(1);
`ifdef CCFF_READBACK_EN
                  crc_tx_d   = crc8_step(crc_tx_q, buf_q[0]);
`endif
               end
               // A new word may land in the same cycle the last buffered bit leaves.
               if (accept_c) begin
                  buf_d      = word_data;
                  buf_left_d = take_c;
                  acc_d      = acc_q + CNT_W'(take_c);
               end
            end
         end

`ifdef CCFF_READBACK_EN
         // Alternate sample/shift so the head always copies a settled tail bit.
         S_VERIFY: begin
            if (en_q) begin
               crc_rx_d = crc8_step(crc_rx_q, ccff_tail);
            end else if (vcnt_q == LEN_C) begin
               verr_d  = (crc_tx_q != crc_rx_q);
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               head_d  = ccff_tail;
               en_d    = 1'b1;
               vcnt_d  = vcnt_q + CNT_W'(1);
            end
         end
`endif

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q    <= S_IDLE;
         buf_q      <= '0;
         buf_left_q <= '0;
         sent_q     <= '0;
         acc_q      <= '0;
         head_q     <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
         crc_tx_q   <= '0;
         crc_rx_q   <= '0;
         vcnt_q     <= '0;
         verr_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         buf_left_q <= buf_left_d;
         sent_q     <= sent_d;
         acc_q      <= acc_d;
         head_q     <= head_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef CCFF_READBACK_EN
         crc_tx_q   <= crc_tx_d;
         crc_rx_q   <= crc_rx_d;
         vcnt_q     <= vcnt_d;
         verr_q     <= verr_d;
`endif
      end
   end

   assign ccff_head   = head_q;
   assign prog_clk_en = en_q;
   assign busy        = busy_q;
   assign done        = done_q;
`ifdef CCFF_READBACK_EN
   assign verify_err  = verr_q;
`else
   assign verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 24-bit and 20-bit loaders with behavioural chain models
// and a bit-level scoreboard of the expected head stream.
module tb_ccff_chain_loader;

   localparam int unsigned W  = 8;
   localparam int unsigned L0 = 24;
   localparam int unsigned L1 = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst    [2];
   logic         start  [2];
   logic [W-1:0] wdata  [2];
   logic         wvalid [2];
   logic         wready [2];
   logic         head   [2];
   logic         tail   [2];
   logic         en     [2];
   logic         busy   [2];
   logic         done   [2];
   logic         verr   [2];

   logic [L0-1:0] ch0 = '0;
   logic [L1-1:0] ch1 = '0;
   logic          flip_now = 1'b0;
   logic [4:0]    flip_idx = '0;

   bit   exp_q    [2][$];
   bit   strm     [2][$];
   int   pushed   [2];
   int   en_cnt   [2];
   int   flip_pos [2];
   logic last_head[2];
   logic acc_seen [2];
   int   n_chk  = 0;
   int   n_pass = 0;

   ccff_chain_loader #(.CHAIN_LEN(L0), .WORD_W(W)) u_dut0 (
      .prog_clk(clk), .prog_reset(rst[0]), .start(start[0]), .word_data(wdata[0]),
      .word_valid(wvalid[0]), .word_ready(wready[0]), .ccff_head(head[0]), .ccff_tail(tail[0]),
      .prog_clk_en(en[0]), .busy(busy[0]), .done(done[0]), .verify_err(verr[0]));

   ccff_chain_loader #(.CHAIN_LEN(L1), .WORD_W(W)) u_dut1 (
      .prog_clk(clk), .prog_reset(rst[1]), .start(start[1]), .word_data(wdata[1]),
      .word_valid(wvalid[1]), .word_ready(wready[1]), .ccff_head(head[1]), .ccff_tail(tail[1]),
      .prog_clk_en(en[1]), .busy(busy[1]), .done(done[1]), .verify_err(verr[1]));

   assign tail[0] = ch0[L0-1];
   assign tail[1] = ch1[L1-1];

   // Fabric chains: shift on the edge after the loader raises prog_clk_en.
   always @(posedge clk) begin
      if (flip_now) ch0[flip_idx] <= ~ch0[flip_idx];
      else if (en[0] === 1'b1) ch0 <= {ch0[L0-2:0], head[0]};
      if (en[1] === 1'b1) ch1 <= {ch1[L1-2:0], head[1]};
   end

   function automatic int len(input int i);
      return (i == 0) ? int'(L0) : int'(L1);
   endfunction

   function automatic logic [31:0] chain_vec(input int i);
      return (i == 0) ? 32'(ch0) : 32'(ch1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic sb_clear(input int i);
      exp_q[i].delete();
      strm[i].delete();
      pushed[i] = 0;
      en_cnt[i] = 0;
   endtask

   task automatic push_word(input int i, input logic [W-1:0] w);
      for (int b = 0; b < int'(W); b++) begin
         if (pushed[i] < len(i)) begin
            exp_q[i].push_back(w[b]);
            strm[i].push_back(w[b]);
            pushed[i]++;
`ifdef CCFF_READBACK_EN
            if (pushed[i] == len(i)) begin
               for (int k = 0; k < len(i); k++)
                  exp_q[i].push_back(strm[i][k] ^ (k == len(i) - 1 - flip_pos[i]));
            end
`endif
         end
      end
   endtask

   // One clock: note accepts, then check the head against the scoreboard.
   task automatic tick();
      logic acc [2];
      for (int i = 0; i < 2; i++) acc[i] = (wvalid[i] && wready[i]) === 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         acc_seen[i] = acc[i];
         if (acc[i]) push_word(i, wdata[i]);
         if (en[i] === 1'b1) begin
            logic e;
            e = 1'bx;
            if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
            en_cnt[i]++;
            chk($sformatf("head%0d_bit%0d", i, en_cnt[i]), 32'(head[i]), 32'(e));
         end else if (busy[i] === 1'b1) begin
            chk($sformatf("head%0d_hold", i), 32'(head[i]), 32'(last_head[i]));
         end
         last_head[i] = head[i];
      end
   endtask

   task automatic run_load(input int i, input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input int stall_at, input bit mid_start,
                           input int flip);
      logic [W-1:0] words [3];
      logic [31:0]  ev;
      logic         prev;
      bit           flipped;
      int           guard;
      words[0] = w0; words[1] = w1; words[2] = w2;
      flip_pos[i] = flip;
      flipped = 1'b0;
      prev = 1'b0;
      sb_clear(i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      chk("busy_after_start", 32'(busy[i]), 32'(1));
      chk("done_cleared", 32'(done[i]), 32'(0));
      for (int k = 0; k < 3; k++) begin
         if (k == stall_at) begin
            wvalid[i] = 1'b0;
            guard = 0;
            while (wready[i] !== 1'b1 && guard < 40) begin tick(); guard++; end
            tick();
            for (int s = 0; s < 4; s++) begin
               tick();
               chk("stall_en_low", 32'(en[i]), 32'(0));
            end
         end
         wvalid[i] = 1'b1;
         wdata[i]  = words[k];
         if (mid_start && k == 1) start[i] = 1'b1;
         guard = 0;
         do begin
            tick();
            start[i] = 1'b0;
            guard++;
         end while (!acc_seen[i] && guard < 40);
         if (!acc_seen[i]) chk("accept_timeout", 32'(acc_seen[i]), 32'(1));
      end
      wvalid[i] = 1'b0;
      guard = 0;
      while (done[i] !== 1'b1 && guard < 200) begin
         prev = en[i];
         tick();
         guard++;
         chk("ready_low_after_last", 32'(wready[i]), 32'(0));
         if (flip >= 0 && !flipped && en_cnt[i] == len(i) && en[i] === 1'b0) begin
            flip_idx = 5'(flip);
            flip_now = 1'b1;
            flipped  = 1'b1;
         end else begin
            flip_now = 1'b0;
         end
      end
      flip_now = 1'b0;
      chk("done_set", 32'(done[i]), 32'(1));
      chk("busy_clear", 32'(busy[i]), 32'(0));
`ifdef CCFF_READBACK_EN
      chk("en_count", 32'(en_cnt[i]), 32'(2 * len(i)));
      chk("verify_err", 32'(verr[i]), 32'(flip >= 0));
`else
      chk("done_latency", 32'(prev), 32'(1));
      chk("en_count", 32'(en_cnt[i]), 32'(len(i)));
      chk("verify_err", 32'(verr[i]), 32'(0));
`endif
      chk("sb_drained", 32'(exp_q[i].size()), 32'(0));
      if (flip < 0) begin
         ev = '0;
         for (int k = 0; k < len(i); k++) ev[k] = strm[i][len(i) - 1 - k];
         chk("chain_contents", chain_vec(i), ev);
      end
      tick();
      chk("done_sticky", 32'(done[i]), 32'(1));
      chk("en_idle", 32'(en[i]), 32'(0));
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; wvalid[i] = 1'b0; wdata[i] = '0;
         pushed[i] = 0; en_cnt[i] = 0; flip_pos[i] = -1; last_head[i] = 1'b0; acc_seen[i] = 1'b0;
      end
      tick(); tick(); tick();
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", 32'(wready[i]), 32'(0));
         chk("rst_head", 32'(head[i]), 32'(0));
         chk("rst_en", 32'(en[i]), 32'(0));
         chk("rst_busy", 32'(busy[i]), 32'(0));
         chk("rst_done", 32'(done[i]), 32'(0));
         chk("rst_verr", 32'(verr[i]), 32'(0));
         rst[i] = 1'b0;
      end
      tick();

      run_load(0, 8'hA5, 8'h3C, 8'hFF, -1, 1'b0, -1);
      run_load(0, 8'hA5, 8'h3C, 8'hFF, 1, 1'b0, -1);
      run_load(1, 8'h0F, 8'hF0, 8'hFF, -1, 1'b0, -1);

      // Reset partway through a load, then reload from scratch.
      sb_clear(0);
      flip_pos[0] = -1;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      wvalid[0] = 1'b1;
      wdata[0]  = 8'h5A;
      guard = 0;
      while (en_cnt[0] < 10 && guard < 100) begin
         tick();
         if (acc_seen[0]) wdata[0] = wdata[0] + 8'h11;
         guard++;
      end
      chk("pre_reset_bits", 32'(en_cnt[0]), 32'(10));
      wvalid[0] = 1'b0;
      rst[0] = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(wready[0]), 32'(0));
      chk("mid_rst_head", 32'(head[0]), 32'(0));
      chk("mid_rst_en", 32'(en[0]), 32'(0));
      chk("mid_rst_busy", 32'(busy[0]), 32'(0));
      chk("mid_rst_done", 32'(done[0]), 32'(0));
      chk("mid_rst_verr", 32'(verr[0]), 32'(0));
      rst[0] = 1'b0;
      tick();
      chk("idle_after_rst", 32'(busy[0]), 32'(0));
      run_load(0, 8'h96, 8'h0E, 8'h71, -1, 1'b0, -1);

      run_load(0, 8'h12, 8'h34, 8'h56, -1, 1'b1, -1);
`ifdef CCFF_READBACK_EN
      run_load(0, 8'hA5, 8'h3C, 8'hFF, -1, 1'b0, 5);
      run_load(0, 8'hC3, 8'h81, 8'h7E, -1, 1'b0, -1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
